zero_count_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle 32-bit zero detector. Counts leading zeros (CLZ) or leading ones (CLO) of a WIDTH-bit operand and also reports an all-zero flag.
- Scans CHUNK bits per cycle under a start/busy/valid handshake. Exits early at the first chunk that contains a match.
- Sits beside the ALU as the backing unit for clz/clo-style instructions and for zero tests that are too wide for a single cycle.

---
 rtl/zero_count_seq_pkg.sv | 13 +
 rtl/zero_count_seq_chunk_lzc.sv | 18 +
 rtl/zero_count_seq.sv | 107 ++++++++++
 tb/tb_zero_count_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/zero_count_seq_pkg.sv
// Shared definitions for the multi-cycle leading-zero/leading-one counter.
package zero_count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_CLZ = 1'b0;
    localparam logic MODE_CLO = 1'b1;

endpackage

// File: rtl/zero_count_seq_chunk_lzc.sv
// Combinational leading-zero count of an N-bit chunk; returns N when the chunk is all zero.
module chunk_lzc #(
    parameter  int unsigned N  = 4,
    localparam int unsigned LW = $clog2(N + 1)
) (
    input  logic [N-1:0]  bits,
    output logic [LW-1:0] lz
);

    // Ascending scan: the highest set bit is the last assignment and wins.
    always_comb begin
        lz = LW'(N);
        for (int unsigned i = 0; i < N; i++) begin
            if (bits[i]) lz = LW'(N - 1 - i);
        end
    end

endmodule

// File: rtl/zero_count_seq.sv
// Multi-cycle CLZ/CLO unit: scans CHUNK bits per cycle from the MSB and exits at the first non-zero chunk.
module zero_count_seq
    import zero_count_seq_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned CHUNK = 4,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] source,
    output logic             busy,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic             is_zero
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned LW  = $clog2(CHUNK + 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    acc;
    logic [IW-1:0]    idx;
    logic             is_zero_r;
    logic [CHUNK-1:0] top;
    logic [LW-1:0]    top_lz;
    logic             last;
    logic             load, step, finish;

    assign top  = shreg[WIDTH-1 -: CHUNK];
    assign last = (idx == IW'(NCH - 1));

    chunk_lzc #(.N(CHUNK)) u_lzc (
        .bits (top),
        .lz   (top_lz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        valid      = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (top == '0 && !last) begin
                    step = 1'b1;
                end else begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                valid      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // An all-zero final chunk yields top_lz == CHUNK, so one sum covers both exit cases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            acc       <= '0;
            idx       <= '0;
            is_zero_r <= 1'b0;
            count     <= '0;
            is_zero   <= 1'b0;
        end else begin
            if (load) begin
                shreg     <= (mode == MODE_CLO) ? ~source : source;
                is_zero_r <= (source == '0);
                acc       <= '0;
                idx       <= '0;
            end
            if (step) begin
                acc   <= acc + CW'(CHUNK);
                shreg <= shreg << CHUNK;
                idx   <= idx + 1'b1;
            end
            if (finish) begin
                count   <= acc + CW'(top_lz);
                is_zero <= is_zero_r;
            end
        end
    end

endmodule

// File: tb/tb_zero_count_seq.sv
// Directed bench for zero_count_seq: default 32/4 instance plus a parameter sweep against a reference model.
module tb_zero_count_seq;
    import zero_count_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = MODE_CLZ;
    logic [31:0] source = '0;
    logic        busy, valid, is_zero;
    logic [5:0]  count;

    logic        s_start = 1'b0;
    logic        s_mode = MODE_CLZ;
    logic [63:0] s_src = '0;
    logic        b16, v16, z16, b64, v64, z64, b32, v32, z32;
    logic [4:0]  c16;
    logic [6:0]  c64;
    logic [5:0]  c32;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    zero_count_seq u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .source(source),
        .busy(busy), .valid(valid), .count(count), .is_zero(is_zero)
    );

    zero_count_seq #(.WIDTH(16), .CHUNK(1)) u_w16 (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .source(s_src[15:0]),
        .busy(b16), .valid(v16), .count(c16), .is_zero(z16)
    );

    zero_count_seq #(.WIDTH(64), .CHUNK(8)) u_w64 (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .source(s_src),
        .busy(b64), .valid(v64), .count(c64), .is_zero(z64)
    );

    zero_count_seq #(.WIDTH(32), .CHUNK(32)) u_w32 (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .source(s_src[31:0]),
        .busy(b32), .valid(v32), .count(c32), .is_zero(z32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_lz(input logic [63:0] v, input int w, input logic m);
        for (int i = w - 1; i >= 0; i--) begin
            if ((v[i] ^ m) == 1'b1) return w - 1 - i;
        end
        return w;
    endfunction

    function automatic logic ref_zero(input logic [63:0] v, input int w);
        for (int i = 0; i < w; i++) begin
            if (v[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int ref_lat(input int lz, input int w, input int ch);
        int j;
        j = lz / ch;
        if (j > w / ch - 1) j = w / ch - 1;
        return j + 1;
    endfunction

    task automatic launch(input logic m, input logic [31:0] s);
        @(negedge clk);
        mode   = m;
        source = s;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Edges after the accepting edge until valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (valid) return;
        end
        lat = -1;
    endtask

    task automatic run_op(input string tag, input logic m, input logic [31:0] s,
                          input int exp_cnt, input logic exp_z, input int exp_lat);
        int lat;
        launch(m, s);
        wait_valid(lat);
        check({tag, "_lat"},   lat,     exp_lat);
        check({tag, "_count"}, count,   exp_cnt);
        check({tag, "_zero"},  is_zero, exp_z);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {busy, valid}, 2'b00);
    endtask

    task automatic sweep(input logic m, input logic [63:0] v);
        int n16, n64, n32, l16, l64, l32, e16, e64, e32;
        n16 = 0; n64 = 0; n32 = 0; l16 = -1; l64 = -1; l32 = -1;
        @(negedge clk);
        s_mode  = m;
        s_src   = v;
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk);
            #1;
            if (v16) begin n16++; l16 = e; end
            if (v64) begin n64++; l64 = e; end
            if (v32) begin n32++; l32 = e; end
        end
        e16 = ref_lz(v, 16, m);
        e64 = ref_lz(v, 64, m);
        e32 = ref_lz(v, 32, m);
        check("w16_count", c16, e16);
        check("w16_zero",  z16, ref_zero(v, 16));
        check("w16_lat",   l16, ref_lat(e16, 16, 1));
        check("w16_npulse", n16, 1);
        check("w64_count", c64, e64);
        check("w64_zero",  z64, ref_zero(v, 64));
        check("w64_lat",   l64, ref_lat(e64, 64, 8));
        check("w64_npulse", n64, 1);
        check("w32c_count", c32, e32);
        check("w32c_zero",  z32, ref_zero(v, 32));
        check("w32c_lat",   l32, ref_lat(e32, 32, 32));
        check("w32c_npulse", n32, 1);
    endtask

    initial begin
        int lat;
        int stray;

        #12;
        check("rst_outputs", {busy, valid, count, is_zero}, '0);
        @(negedge clk) rst = 1'b0;

        run_op("clz_fad", MODE_CLZ, 32'hfad21321, 0,  1'b0, 1);
        run_op("clz_0",   MODE_CLZ, 32'h00000000, 32, 1'b1, 8);
        run_op("clo_1s",  MODE_CLO, 32'hFFFFFFFF, 32, 1'b0, 8);
        run_op("clz_1",   MODE_CLZ, 32'h00000001, 31, 1'b0, 8);
        run_op("clz_msb", MODE_CLZ, 32'h80000000, 0,  1'b0, 1);
        run_op("clo_f0",  MODE_CLO, 32'hF0000000, 4,  1'b0, 2);

        // start held high; source altered while scanning.
        @(negedge clk);
        mode   = MODE_CLZ;
        source = 32'h00F00000;
        start  = 1'b1;
        @(posedge clk);
        #1;
        check("hold_busy", busy, 1'b1);
        @(negedge clk) source = 32'h0;
        wait_valid(lat);
        check("hold_lat",   lat,     3);
        check("hold_count", count,   8);
        check("hold_zero",  is_zero, 1'b0);
        @(posedge clk);
        #1;
        check("hold_idle_gap", {busy, valid}, 2'b00);
        @(posedge clk);
        #1;
        check("hold_reaccept", busy, 1'b1);
        check("hold_count_stable", count, 8);
        start = 1'b0;
        wait_valid(lat);
        check("hold2_lat",   lat,     8);
        check("hold2_count", count,   32);
        check("hold2_zero",  is_zero, 1'b1);

        // Asynchronous reset mid-scan.
        launch(MODE_CLZ, 32'h0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_outputs", {busy, valid, count, is_zero}, '0);
        @(negedge clk) rst = 1'b0;
        stray = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (valid) stray++;
        end
        check("arst_no_valid", stray, 0);
        run_op("clz_post_rst", MODE_CLZ, 32'h00010000, 15, 1'b0, 4);

        sweep(MODE_CLZ, 64'h0);
        sweep(MODE_CLO, 64'hFFFFFFFF_FFFFFFFF);
        sweep(MODE_CLZ, 64'hFFFFFFFF_FFFFFFFF);
        sweep(MODE_CLO, 64'h0);
        for (int r = 0; r < 8; r++) begin
            logic [63:0] v;
            v = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) v = ~v;
            sweep(logic'($urandom_range(0, 1)), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
